// File: rtl/tt_sweep_capture_if.sv
// Bus bundle between the truth-table capture stage, the netlist it drives
// and the consumer of the finished table.
interface tt_sweep_capture_if #(
    parameter int NVARS = 7
) ();
    localparam int TTW = 1 << NVARS;

    logic             start;
    logic             abort;
    logic [TTW-1:0]   exp_tt;
    logic [NVARS-1:0] x_vec;
    logic             f_in;
    logic             busy;
    logic [TTW-1:0]   tt;
    logic [NVARS:0]   ones;
    logic             match;
    logic             tt_valid;
    logic             tt_ready;

    // Capture stage side
    modport slave (
        input  start, abort, exp_tt, f_in, tt_ready,
        output x_vec, busy, tt, ones, match, tt_valid
    );

    // Controller / netlist / consumer side
    modport master (
        output start, abort, exp_tt, f_in, tt_ready,
        input  x_vec, busy, tt, ones, match, tt_valid
    );
endinterface

// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table capture: walks every minterm of an NVARS-input
// netlist, samples its output per minterm (after SETTLE extra cycles),
// and presents the assembled table, its popcount and an expected-table
// compare through a valid/ready handshake.
module tt_sweep_capture #(
    parameter int NVARS  = 7,
    parameter int SETTLE = 0
) (
    input logic               clk,
    input logic               rst,
    tt_sweep_capture_if.slave bus
);
    localparam int TTW = 1 << NVARS;
    localparam int SW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE);
    localparam logic [NVARS-1:0] M_LAST      = {NVARS{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [NVARS-1:0] m_r;
    logic [SW-1:0]    s_r;
    logic [TTW-1:0]   exp_r;
    logic [NVARS-1:0] x_vec_r;
    logic             busy_r;
    logic [TTW-1:0]   tt_r;
    logic [NVARS:0]   ones_r;
    logic             match_r;
    logic             tt_valid_r;
    logic [TTW-1:0]   tt_upd_s;

    // Table as it will look once the current minterm's sample is written;
    // used both for the write and for the compare on the final minterm.
    always_comb begin
        tt_upd_s       = tt_r;
        tt_upd_s[m_r]  = bus.f_in;
    end

    // Sweep controller: IDLE -> SWEEP -> DONE, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            m_r        <= '0;
            s_r        <= '0;
            exp_r      <= '0;
            x_vec_r    <= '0;
            busy_r     <= 1'b0;
            tt_r       <= '0;
            ones_r     <= '0;
            match_r    <= 1'b0;
            tt_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // start beats a simultaneous abort here
                    if (bus.start) begin
                        state_r  <= SWEEP;
                        m_r      <= '0;
                        s_r      <= '0;
                        tt_r     <= '0;
                        ones_r   <= '0;
                        match_r  <= 1'b0;
                        exp_r    <= bus.exp_tt;
                        x_vec_r  <= '0;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                SWEEP: begin
                    if (bus.abort) begin
                        // partial tt/ones are left in place
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        x_vec_r  <= '0;
                    end else if (s_r != SETTLE_LAST) begin
                        s_r      <= s_r + 1'b1;
                    end else begin
                        s_r      <= '0;
                        tt_r     <= tt_upd_s;
                        ones_r   <= ones_r + {{NVARS{1'b0}}, bus.f_in};
                        if (m_r == M_LAST) begin
                            // terminal minterm: no wrap, result goes out
                            state_r    <= DONE;
                            busy_r     <= 1'b0;
                            tt_valid_r <= 1'b1;
                            match_r    <= (tt_upd_s == exp_r);
                        end else begin
                            m_r      <= m_r + 1'b1;
                            x_vec_r  <= m_r + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start and abort are ignored until the result is taken
                    if (tt_valid_r && bus.tt_ready) begin
                        state_r    <= IDLE;
                        tt_valid_r <= 1'b0;
                        x_vec_r    <= '0;
                    end else begin
                        state_r    <= DONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    tt_valid_r <= 1'b0;
                    x_vec_r    <= '0;
                end
            endcase
        end
    end

    assign bus.x_vec    = x_vec_r;
    assign bus.busy     = busy_r;
    assign bus.tt       = tt_r;
    assign bus.ones     = ones_r;
    assign bus.match    = match_r;
    assign bus.tt_valid = tt_valid_r;
endmodule
